// File: rtl/fetch_unit.sv
// Fetch stage of the 4-bit processor: program counter, fetch/execute phase bit and fetch register.
// Optional breakpoint/halt support is built when FETCH_BREAKPOINT_EN is defined.
module fetch_unit #(
  parameter int PC_W   = 12,
  parameter int BYTE_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              enable,
  input  logic              IncPC,
  input  logic              LoadPC,
  input  logic [BYTE_W-1:0] program_byte,
`ifdef FETCH_BREAKPOINT_EN
  input  logic [PC_W-1:0]   bp_addr,
  input  logic              bp_valid,
  input  logic              resume,
  output logic              halted,
`endif
  output logic [PC_W-1:0]   PC,
  output logic              Phase,
  output logic [3:0]        Instr,
  output logic [3:0]        Oprnd
);

  logic [PC_W-1:0]   pc_r;
  logic              phase_r;
  logic [BYTE_W-1:0] fetch_r;
  logic [PC_W-1:0]   pc_next_s;
  logic              phase_next_s;
  logic [BYTE_W-1:0] fetch_next_s;
  logic              run_s;

`ifdef FETCH_BREAKPOINT_EN
  logic halted_r;
  logic bp_skip_r;
  logic bp_hit_s;

  // Breakpoint match; suppressed for the first enabled edge after a resume.
  always_comb begin
    bp_hit_s = 1'b0;
    if (bp_valid && !phase_r && (pc_r == bp_addr) && !bp_skip_r) begin
      bp_hit_s = 1'b1;
    end else begin
      bp_hit_s = 1'b0;
    end
  end

  // Advance qualifier: a halted block or a breakpoint hit behaves like enable=0.
  always_comb begin
    run_s = enable && !halted_r && !bp_hit_s;
  end

  // Halt flag and the one-shot skip that prevents an immediate re-trigger.
  always_ff @(posedge clock) begin
    if (reset) begin
      halted_r  <= 1'b0;
      bp_skip_r <= 1'b0;
    end else if (halted_r) begin
      if (resume) begin
        halted_r  <= 1'b0;
        bp_skip_r <= 1'b1;
      end else begin
        halted_r  <= 1'b1;
      end
    end else if (enable && bp_hit_s) begin
      halted_r <= 1'b1;
    end else if (enable) begin
      bp_skip_r <= 1'b0;
    end else begin
      halted_r <= halted_r;
    end
  end
`else
  // Advance qualifier: without breakpoint support only enable gates the stage.
  always_comb begin
    run_s = enable;
  end
`endif

  // State register: phase, fetch register and program counter.
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_r    <= {PC_W{1'b0}};
      phase_r <= 1'b0;
      fetch_r <= {BYTE_W{1'b0}};
    end else begin
      pc_r    <= pc_next_s;
      phase_r <= phase_next_s;
      fetch_r <= fetch_next_s;
    end
  end

  // Next-state logic; a jump target takes its high nibble from the held operand.
  always_comb begin
    pc_next_s    = pc_r;
    phase_next_s = phase_r;
    fetch_next_s = fetch_r;
    if (run_s) begin
      phase_next_s = ~phase_r;
      case (phase_r)
        1'b0:    fetch_next_s = program_byte;
        1'b1:    fetch_next_s = fetch_r;
        default: fetch_next_s = fetch_r;
      endcase
      if (LoadPC) begin
        pc_next_s = {fetch_r[3:0], program_byte};
      end else if (IncPC) begin
        pc_next_s = pc_r + PC_W'(1);
      end else begin
        pc_next_s = pc_r;
      end
    end else begin
      pc_next_s    = pc_r;
      phase_next_s = phase_r;
      fetch_next_s = fetch_r;
    end
  end

  // Outputs are taken straight from the registers.
  always_comb begin
    PC    = pc_r;
    Phase = phase_r;
    Instr = fetch_r[BYTE_W-1:BYTE_W-4];
    Oprnd = fetch_r[3:0];
`ifdef FETCH_BREAKPOINT_EN
    halted = halted_r;
`endif
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed, table-driven bench for fetch_unit; breakpoint sequence built with FETCH_BREAKPOINT_EN.
module tb_fetch_unit;

  logic        clock = 1'b0;
  logic        reset, enable, IncPC, LoadPC;
  logic [7:0]  program_byte;
  logic [11:0] pc;
  logic        phase;
  logic [3:0]  instr, oprnd;
`ifdef FETCH_BREAKPOINT_EN
  logic [11:0] bp_addr;
  logic        bp_valid, resume, halted;
`endif

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        rst, en, inc, ld;
    logic [7:0]  pb;
    logic [11:0] pc;
    logic        ph;
    logic [3:0]  ins, op;
  } vec_t;

  vec_t vecs[18];

  fetch_unit dut (
    .clock(clock), .reset(reset), .enable(enable), .IncPC(IncPC), .LoadPC(LoadPC),
    .program_byte(program_byte),
`ifdef FETCH_BREAKPOINT_EN
    .bp_addr(bp_addr), .bp_valid(bp_valid), .resume(resume), .halted(halted),
`endif
    .PC(pc), .Phase(phase), .Instr(instr), .Oprnd(oprnd)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic check_state(input string tag, input logic [11:0] epc, input logic eph,
                             input logic [3:0] ei, input logic [3:0] eo);
    check({tag, ".PC"}, pc, epc);
    check({tag, ".Phase"}, {11'd0, phase}, {11'd0, eph});
    check({tag, ".Instr"}, {8'd0, instr}, {8'd0, ei});
    check({tag, ".Oprnd"}, {8'd0, oprnd}, {8'd0, eo});
  endtask

  initial begin
    //           rst   en    inc   ld    pb      pc        ph    ins   op
    vecs[0]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h4A, 12'h000, 1'b0, 4'h0, 4'h0};
    vecs[1]  = '{1'b1, 1'b1, 1'b1, 1'b0, 8'h4A, 12'h000, 1'b0, 4'h0, 4'h0};
    vecs[2]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h4A, 12'h001, 1'b1, 4'h4, 4'hA};
    vecs[3]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h00, 12'h002, 1'b0, 4'h4, 4'hA};
    vecs[4]  = '{1'b0, 1'b1, 1'b1, 1'b0, 8'hC3, 12'h003, 1'b1, 4'hC, 4'h3};
    vecs[5]  = '{1'b0, 1'b1, 1'b1, 1'b1, 8'h21, 12'h321, 1'b0, 4'hC, 4'h3};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 12'h321, 1'b0, 4'hC, 4'h3};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 12'h321, 1'b0, 4'hC, 4'h3};
    vecs[8]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 12'h321, 1'b0, 4'hC, 4'h3};
    vecs[9]  = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 12'h321, 1'b0, 4'hC, 4'h3};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 1'b0, 8'h99, 12'h321, 1'b0, 4'hC, 4'h3};
    vecs[11] = '{1'b1, 1'b0, 1'b1, 1'b0, 8'h99, 12'h000, 1'b0, 4'h0, 4'h0};
    // load in fetch phase uses the old operand (0), the new byte fills the fetch register
    vecs[12] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 12'h0FF, 1'b1, 4'hF, 4'hF};
    vecs[13] = '{1'b0, 1'b1, 1'b0, 1'b1, 8'hFF, 12'hFFF, 1'b0, 4'hF, 4'hF};
    vecs[14] = '{1'b0, 1'b1, 1'b1, 1'b0, 8'h5A, 12'h000, 1'b1, 4'h5, 4'hA};
    vecs[15] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h77, 12'h000, 1'b0, 4'h5, 4'hA};
    vecs[16] = '{1'b0, 1'b1, 1'b0, 1'b0, 8'h66, 12'h000, 1'b1, 4'h6, 4'h6};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 1'b1, 8'h66, 12'h000, 1'b0, 4'h0, 4'h0};

    reset = 1'b1; enable = 1'b1; IncPC = 1'b0; LoadPC = 1'b0; program_byte = 8'h00;
`ifdef FETCH_BREAKPOINT_EN
    bp_addr = 12'h000; bp_valid = 1'b0; resume = 1'b0;
`endif
    #1;

    for (int i = 0; i < 18; i++) begin
      reset = vecs[i].rst; enable = vecs[i].en; IncPC = vecs[i].inc;
      LoadPC = vecs[i].ld; program_byte = vecs[i].pb;
      step();
      check_state($sformatf("vec%0d", i), vecs[i].pc, vecs[i].ph, vecs[i].ins, vecs[i].op);
    end

    // Disabled stage ignores LoadPC; then a jump in execute phase after a normal fetch.
    reset = 1'b0; enable = 1'b0; IncPC = 1'b0; LoadPC = 1'b1; program_byte = 8'hAB;
    for (int k = 0; k < 3; k++) step();
    check_state("hold_load", 12'h000, 1'b0, 4'h0, 4'h0);
    enable = 1'b1; LoadPC = 1'b0; IncPC = 1'b1; program_byte = 8'h9E;
    step();
    LoadPC = 1'b1; program_byte = 8'h00;
    step();
    check_state("jump_e00", 12'hE00, 1'b0, 4'h9, 4'hE);

`ifdef FETCH_BREAKPOINT_EN
    begin
      logic [11:0] exp_pc;
      logic        exp_ph;
      reset = 1'b1; IncPC = 1'b0; LoadPC = 1'b0;
      step();
      reset = 1'b0; bp_addr = 12'h005; bp_valid = 1'b1;
      exp_pc = 12'h000; exp_ph = 1'b0;
      for (int k = 0; k < 10; k++) begin
        program_byte = 8'h10 + exp_pc[7:0];
        IncPC = ~exp_ph;
        step();
        if (!exp_ph) exp_pc = exp_pc + 12'd1;
        exp_ph = ~exp_ph;
      end
      check_state("bp_pre", exp_pc, exp_ph, 4'h1, 4'h4);
      check("bp_pre.halted", {11'd0, halted}, 12'd0);
      program_byte = 8'h15; IncPC = 1'b1;
      step();
      check_state("bp_hit", 12'h005, 1'b0, 4'h1, 4'h4);
      check("bp_hit.halted", {11'd0, halted}, 12'd1);
      step();
      check_state("bp_stay", 12'h005, 1'b0, 4'h1, 4'h4);
      check("bp_stay.halted", {11'd0, halted}, 12'd1);
      resume = 1'b1;
      step();
      resume = 1'b0;
      check_state("bp_resume", 12'h005, 1'b0, 4'h1, 4'h4);
      check("bp_resume.halted", {11'd0, halted}, 12'd0);
      step();
      check_state("bp_fetch", 12'h006, 1'b1, 4'h1, 4'h5);
      check("bp_fetch.halted", {11'd0, halted}, 12'd0);
    end
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
